dead_time_generator_mc: RTL and testbench

- Multi-channel, parametrised successor of the single-leg dead-time block.
- Sits between the PWM carrier/comparator stage and the gate-driver outputs. Inserts independently programmable dead times for each transition direction on N complementary legs.
- Adds a safe OFF state, pulse-abort handling, zero-dead-time bypass and optional shoot-through fault latching.

---
 rtl/dead_time_pkg.sv | 15 +
 rtl/dead_time_channel.sv | 128 ++++++++++++
 rtl/dead_time_generator_mc.sv | 69 ++++++
 tb/tb_dead_time_generator_mc.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dead_time_pkg.sv
// Shared definitions for the multi-channel dead-time generator: the per-leg
// state encoding and the default counter width.
package dead_time_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 16;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    DT_TO_A = 3'd1,
    A_ON    = 3'd2,
    DT_TO_B = 3'd3,
    B_ON    = 3'd4
  } dt_state_e;

endpackage

// File: rtl/dead_time_channel.sv
// One complementary leg: state machine, dead-time counter and registered gate
// commands. force_off parks the leg in OFF with both gates low whatever the
// enable state; enable low turns the leg into a one-cycle register.
module dead_time_channel
  import dead_time_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     force_off,
  input  logic [COUNTER_WIDTH-1:0] dead_time_a,
  input  logic [COUNTER_WIDTH-1:0] dead_time_b,
  input  logic                     in_a,
  input  logic                     in_b,
  output logic                     out_a,
  output logic                     out_b,
  output logic                     busy
);

  dt_state_e                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     req_a, req_b;

  // A request is only valid when exactly one side asks to conduct.
  assign req_a = in_a & ~in_b;
  assign req_b = in_b & ~in_a;

  // Next-state and counter reload; an abort or redirect outranks the DT exit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_off || !enable) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF, B_ON: begin
          if (req_a) begin
            // A zero dead time skips the gap entirely.
            if (dead_time_a == '0) begin
              state_d = A_ON;
            end else begin
              state_d = DT_TO_A;
              cnt_d   = dead_time_a - 1'b1;
            end
          end else if (state_q == OFF && req_b) begin
            if (dead_time_b == '0) begin
              state_d = B_ON;
            end else begin
              state_d = DT_TO_B;
              cnt_d   = dead_time_b - 1'b1;
            end
          end else if (state_q == B_ON && !req_b) begin
            state_d = OFF;
          end
        end
        A_ON: begin
          if (req_b) begin
            if (dead_time_b == '0) begin
              state_d = B_ON;
            end else begin
              state_d = DT_TO_B;
              cnt_d   = dead_time_b - 1'b1;
            end
          end else if (!req_a) begin
            state_d = OFF;
          end
        end
        DT_TO_A: begin
          if (!req_a) begin
            state_d = OFF;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = A_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DT_TO_B: begin
          if (!req_b) begin
            state_d = OFF;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = B_ON;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and gate commands; outputs decode the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      out_a   <= 1'b0;
      out_b   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (force_off) begin
        out_a <= 1'b0;
        out_b <= 1'b0;
        busy  <= 1'b0;
      end else if (!enable) begin
        out_a <= in_a;
        out_b <= in_b;
        busy  <= 1'b0;
      end else begin
        out_a <= (state_d == A_ON);
        out_b <= (state_d == B_ON);
        busy  <= (state_d == DT_TO_A) || (state_d == DT_TO_B);
      end
    end
  end

endmodule

// File: rtl/dead_time_generator_mc.sv
// Multi-channel dead-time generator: N independent complementary legs sharing
// the two dead-time settings. Optional shoot-through fault latching is built
// when DEAD_TIME_FAULT_DETECT_EN is defined.
module dead_time_generator_mc
  import dead_time_pkg::*;
#(
  parameter int N_CHANNELS    = 3,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [COUNTER_WIDTH-1:0] dead_time_a,
  input  logic [COUNTER_WIDTH-1:0] dead_time_b,
  input  logic [N_CHANNELS-1:0]    in_a,
  input  logic [N_CHANNELS-1:0]    in_b,
`ifdef DEAD_TIME_FAULT_DETECT_EN
  input  logic                     fault_clear,
  output logic [N_CHANNELS-1:0]    fault,
`endif
  output logic [N_CHANNELS-1:0]    out_a,
  output logic [N_CHANNELS-1:0]    out_b,
  output logic [N_CHANNELS-1:0]    busy
);

  logic [N_CHANNELS-1:0] force_off;

`ifdef DEAD_TIME_FAULT_DETECT_EN
  logic [N_CHANNELS-1:0] both_q;
  logic [N_CHANNELS-1:0] fault_d;

  // A new detection wins over a simultaneous clear; the next value also
  // gates the legs so they drop on the very edge the fault latches.
  assign fault_d   = (in_a & in_b & both_q) | (fault & ~{N_CHANNELS{fault_clear}});
  assign force_off = fault_d;

  // Remember last cycle's both-high sample and hold the sticky fault bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      both_q <= '0;
      fault  <= '0;
    end else begin
      both_q <= in_a & in_b;
      fault  <= fault_d;
    end
  end
`else
  assign force_off = '0;
`endif

  for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_channel
    dead_time_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .force_off   (force_off[ch]),
      .dead_time_a (dead_time_a),
      .dead_time_b (dead_time_b),
      .in_a        (in_a[ch]),
      .in_b        (in_b[ch]),
      .out_a       (out_a[ch]),
      .out_b       (out_b[ch]),
      .busy        (busy[ch])
    );
  end

endmodule

// File: tb/tb_dead_time_generator_mc.sv
// Directed bench for dead_time_generator_mc. Observations are packed as
// {out_a, out_b, busy}; expected vectors are built per channel as 3-bit
// {a, b, busy} triples. Fault scenarios run when DEAD_TIME_FAULT_DETECT_EN is defined.
module tb_dead_time_generator_mc;

  localparam int N  = 3;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [CW-1:0] dead_time_a, dead_time_b;
  logic [N-1:0]  in_a, in_b;
  logic [N-1:0]  out_a, out_b, busy;
  logic [3*N-1:0] obs, exp_v;
`ifdef DEAD_TIME_FAULT_DETECT_EN
  logic          fault_clear;
  logic [N-1:0]  fault;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dead_time_generator_mc #(
    .N_CHANNELS    (N),
    .COUNTER_WIDTH (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .dead_time_a (dead_time_a),
    .dead_time_b (dead_time_b),
    .in_a        (in_a),
    .in_b        (in_b),
`ifdef DEAD_TIME_FAULT_DETECT_EN
    .fault_clear (fault_clear),
    .fault       (fault),
`endif
    .out_a       (out_a),
    .out_b       (out_b),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  assign obs = {out_a, out_b, busy};

  // Place one channel's {a, b, busy} triple into the packed observation layout.
  function automatic logic [3*N-1:0] ch_bits(int ch, logic [2:0] e);
    logic [3*N-1:0] v;
    v = '0;
    v[2*N+ch] = e[2];
    v[N+ch]   = e[1];
    v[ch]     = e[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b1;
    in_a        = '0;
    in_b        = '0;
    dead_time_a = 16'd5;
    dead_time_b = 16'd3;
`ifdef DEAD_TIME_FAULT_DETECT_EN
    fault_clear = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    in_a = 3'b101;
    in_b = 3'b010;
    dead_time_a = 16'd0;
    dead_time_b = 16'd0;
`ifdef DEAD_TIME_FAULT_DETECT_EN
    fault_clear = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("FAIL reset_hold k=%0d got %b want %b", k, obs, {3*N{1'b0}});
      end
    end
`ifdef DEAD_TIME_FAULT_DETECT_EN
    tests_run++;
    if (fault !== '0) begin
      tests_failed++;
      $display("FAIL reset_fault got %b want 000", fault);
    end
`endif
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    in_b[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = (k <= 3) ? ch_bits(0, 3'b001) : ch_bits(0, 3'b010);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL basic_off_to_b k=%0d got %b want %b", k, obs, exp_v);
      end
    end
    in_a[0] = 1'b1;
    in_b[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k <= 5) ? ch_bits(0, 3'b001) : ch_bits(0, 3'b100);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL basic_b_to_a k=%0d got %b want %b", k, obs, exp_v);
      end
      // Changing the setting mid-gap must not shorten this dead time.
      if (k == 1) dead_time_a = 16'd2;
    end
    in_a[0] = 1'b0;
    in_b[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = (k <= 3) ? ch_bits(0, 3'b001) : ch_bits(0, 3'b010);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL basic_a_to_b k=%0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_zero_dead_time();
    logic [1:0]  seq_in [5];
    logic [2:0]  seq_ex [5];
    do_reset();
    dead_time_a = 16'd0;
    dead_time_b = 16'd0;
    // {in_a, in_b} applied, then expected {a, b, busy} one edge later.
    seq_in = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
    seq_ex = '{3'b100, 3'b100, 3'b010, 3'b000, 3'b010};
    for (int k = 0; k < 5; k++) begin
      in_a[0] = seq_in[k][1];
      in_b[0] = seq_in[k][0];
      tick();
      exp_v = ch_bits(0, seq_ex[k]);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL zero_dt k=%0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    dead_time_a = 16'd10;
    in_a[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) in_a[0] = 1'b0;
      tick();
      exp_v = (k <= 4) ? ch_bits(0, 3'b001) : '0;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL abort_pulse k=%0d got %b want %b", k, obs, exp_v);
      end
    end
    // Request drops on the very edge the counter expires: abort wins.
    dead_time_a = 16'd3;
    in_a[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) in_a[0] = 1'b0;
      tick();
      exp_v = (k <= 3) ? ch_bits(0, 3'b001) : '0;
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL abort_at_exit k=%0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_independent();
    logic [2:0] e0, e2;
    do_reset();
    dead_time_a = 16'd5;
    dead_time_b = 16'd3;
    in_a[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e0 = (k <= 5) ? 3'b001 : 3'b100;
      e2 = (k <= 2) ? 3'b000 : (k <= 5) ? 3'b001 : 3'b010;
      exp_v = ch_bits(0, e0) | ch_bits(2, e2);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL independent k=%0d got %b want %b", k, obs, exp_v);
      end
      if (k == 2) in_b[2] = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dead_time_a = 16'd5;
    in_a[0] = 1'b1;
    tick();
    tick();
    tests_run++;
    if (obs !== ch_bits(0, 3'b001)) begin
      tests_failed++;
      $display("FAIL async_pre got %b want %b", obs, ch_bits(0, 3'b001));
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL async_immediate got %b want %b", obs, {3*N{1'b0}});
    end
    #1 reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k <= 5) ? ch_bits(0, 3'b001) : ch_bits(0, 3'b100);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL async_redo k=%0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [1:0] seq_in [3];
    logic [2:0] seq_ex [3];
    do_reset();
    dead_time_a = 16'd5;
    enable = 1'b0;
    seq_in = '{2'b10, 2'b11, 2'b01};
    seq_ex = '{3'b100, 3'b110, 3'b010};
    for (int k = 0; k < 3; k++) begin
      in_a[0] = seq_in[k][1];
      in_b[0] = seq_in[k][0];
      tick();
      exp_v = ch_bits(0, seq_ex[k]);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL pass_through k=%0d got %b want %b", k, obs, exp_v);
      end
    end
    // Rising enable restarts from OFF, so a full dead time is inserted.
    in_a[0] = 1'b1;
    in_b[0] = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_v = (k <= 5) ? ch_bits(0, 3'b001) : ch_bits(0, 3'b100);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL enable_rise k=%0d got %b want %b", k, obs, exp_v);
      end
    end
  endtask

`ifdef DEAD_TIME_FAULT_DETECT_EN
  task automatic test_fault();
    // Each step: {fault_clear, in_a[1], in_b[1]} then expected ch1 triple and fault.
    logic [2:0] seq_in [8];
    logic [2:0] seq_ex [8];
    logic [N-1:0] seq_f [8];
    do_reset();
    enable = 1'b0;
    seq_in = '{3'b011, 3'b011, 3'b011, 3'b000, 3'b110, 3'b011, 3'b111, 3'b000};
    seq_ex = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b100, 3'b110, 3'b000, 3'b000};
    seq_f  = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010};
    for (int k = 0; k < 8; k++) begin
      fault_clear = seq_in[k][2];
      in_a[1]     = seq_in[k][1];
      in_b[1]     = seq_in[k][0];
      tick();
      exp_v = ch_bits(1, seq_ex[k]);
      tests_run++;
      if (obs !== exp_v || fault !== seq_f[k]) begin
        tests_failed++;
        $display("FAIL fault k=%0d got %b/%b want %b/%b", k, obs, fault, exp_v, seq_f[k]);
      end
    end
    do_reset();
    tests_run++;
    if (fault !== '0) begin
      tests_failed++;
      $display("FAIL fault_reset got %b want 000", fault);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_dead_time();
    test_abort();
    test_independent();
    test_async_reset();
    test_pass_through();
`ifdef DEAD_TIME_FAULT_DETECT_EN
    test_fault();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
